// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares a single SRAM controller between two requesters. One 32-bit read or
// write is serviced at a time: the winning request is latched into the
// controller command registers, the controller is driven until its freeze
// drops, then the winner receives its read data (for reads) and a one-cycle
// ready pulse. Simultaneous requests are resolved round-robin.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_read / reqN_write   per-port request, held until reqN_ready
//   reqN_addr / reqN_wdata   per-port access address and write data
//   reqN_rdata               per-port read data, held until next read done
//   reqN_ready               per-port one-cycle completion pulse
//   reqN_stall               per-port freeze: request pending and not ready
//   ctrl_mem_read/write      command strobes to the SRAM controller
//   ctrl_address/ctrl_data   latched address / write data to the controller
//   ctrl_data_out            read data from the controller
//   ctrl_freeze              controller busy; low while driven = access done
//   grant                    port owning the controller (BUSY/RELEASE)
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_ready,
    output logic              req0_stall,

    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_ready,
    output logic              req1_stall,

    output logic              ctrl_mem_read,
    output logic              ctrl_mem_write,
    output logic [ADDR_W-1:0] ctrl_address,
    output logic [DATA_W-1:0] ctrl_data,
    input  logic [DATA_W-1:0] ctrl_data_out,
    input  logic              ctrl_freeze,

    output logic              grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              req0_any;
    logic              req1_any;
    logic              last_grant;
    logic              win;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req0_any = req0_read | req0_write;
    assign req1_any = req1_read | req1_write;

    // Stall is combinational so a master freezes in the very cycle it asks.
    assign req0_stall = req0_any & ~req0_ready;
    assign req1_stall = req1_any & ~req1_ready;

    // Next-state and winner selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        win        = 1'b0;
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;

        // Tie goes to the port that was not granted last time.
        if (req0_any && req1_any) begin
            win = ~last_grant;
        end else begin
            win = req1_any;
        end

        // Write takes priority when a port raises read and write together.
        if (win) begin
            sel_write = req1_write;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end else begin
            sel_write = req0_write;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
        end

        case (state)
            IDLE: begin
                if (req0_any || req1_any) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (!ctrl_freeze) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: state and all registered outputs use non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command, handshake and read-data registers. The rdata registers are
    // plain flops with a reset value, not a memory, so clearing them is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_mem_read  <= 1'b0;
            ctrl_mem_write <= 1'b0;
            ctrl_address   <= '0;
            ctrl_data      <= '0;
            req0_rdata     <= '0;
            req1_rdata     <= '0;
            req0_ready     <= 1'b0;
            req1_ready     <= 1'b0;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (next_state == BUSY) begin
                        // The controller strobes double as the latched opcode.
                        grant          <= win;
                        last_grant     <= win;
                        ctrl_mem_write <= sel_write;
                        ctrl_mem_read  <= ~sel_write;
                        ctrl_address   <= sel_addr;
                        ctrl_data      <= sel_wdata;
                    end
                end
                BUSY: begin
                    if (!ctrl_freeze) begin
                        // Dropping the strobes for RELEASE lets the controller
                        // return its internal counter to zero.
                        ctrl_mem_read  <= 1'b0;
                        ctrl_mem_write <= 1'b0;
                        if (ctrl_mem_read) begin
                            if (grant) begin
                                req1_rdata <= ctrl_data_out;
                            end else begin
                                req0_rdata <= ctrl_data_out;
                            end
                        end
                        if (grant) begin
                            req1_ready <= 1'b1;
                        end else begin
                            req0_ready <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    req0_ready <= 1'b0;
                    req1_ready <= 1'b0;
                end
                default: begin
                    req0_ready <= 1'b0;
                    req1_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter sharing the single SRAM controller between two requesters (port 0: pipeline MEM stage; port 1: secondary master such as instruction fetch or a DMA engine). It accepts one 32-bit read or write at a time, latches the winner's command, drives the SRAM controller until its freeze drops, then returns read data and a one-cycle ready pulse to the winner. Round-robin arbitration on simultaneous requests; per-port stall outputs freeze the losing or waiting master.

## Interface
- ADDR_W, 18, word address width (matches SRAM controller address)
- DATA_W, 32, data width per access
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_read / req1_read  in  1  read request, held until that port's ready
- req0_write / req1_write  in  1  write request, held until that port's ready; write wins if read and write both high
- req0_addr / req1_addr  in  ADDR_W  access address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_rdata / req1_rdata  out  DATA_W  read data, registered, held until that port's next read completes
- req0_ready / req1_ready  out  1  one-cycle completion pulse
- req0_stall / req1_stall  out  1  (read|write) & ~ready for that port, combinational
- ctrl_mem_read  out  1  to SRAM controller mem_read
- ctrl_mem_write  out  1  to SRAM controller mem_write
- ctrl_address  out  ADDR_W  to SRAM controller address
- ctrl_data  out  DATA_W  to SRAM controller write data
- ctrl_data_out  in  DATA_W  read data from SRAM controller
- ctrl_freeze  in  1  SRAM controller busy; low while a request is held = access done
- grant  out  1  port currently owning the controller (valid in BUSY/RELEASE)

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: ctrl_mem_read/write = 0. If any port requests, choose winner, latch op/addr/wdata into command register, set grant, go BUSY. Otherwise stay.
- Arbitration: only one port requesting -> it wins. Both -> port != last_grant wins. last_grant updated at grant.
- BUSY: ctrl_* driven only from the latched command (requester inputs ignored). When ctrl_freeze = 0: if read, capture ctrl_data_out into req<grant>_rdata; go RELEASE.
- RELEASE: ctrl_mem_read/write = 0 for exactly one cycle (returns controller counter to 0); req<grant>_ready = 1; next state IDLE.
- Requester dropping its request mid-BUSY: access still completes with latched values; ready still pulses.
- Writes do not modify rdata registers. Non-granted port's rdata untouched.
- Reset (any time, including mid-access): state IDLE, ctrl_mem_read/write 0, ctrl_address 0, ctrl_data 0, both ready 0, both rdata 0, grant 0, last_grant 1 (port 0 wins first tie). SRAM controller shares rst.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: BUSY, controller count 0, freeze 1. Cycle 6: controller count 5, freeze 0. Cycle 7: RELEASE, ready = 1, rdata valid. Cycle 8: IDLE, next request may be accepted.
- Fixed service latency: 7 cycles request-to-ready, 8-cycle occupancy per access; no back-to-back overlap.
- Requester must present its next request (or deassert) in the cycle after ready; a request still held in IDLE is a new access.
- ready, rdata, ctrl_* are registered outputs; stall is combinational from inputs and ready.
- Loser of a tie is granted at the next IDLE (cycle 8); worst-case wait 15 cycles.

## Test plan
- Reset then port 0 read 0x00010, SRAM model word 0xDEADBEEF -> ctrl_mem_read high cycles 1-6, req0_ready pulse cycle 7, req0_rdata = 0xDEADBEEF, req0_stall high cycles 0-6.
- Port 1 write addr 0x3FFFE data 0x12345678 -> ctrl_mem_write cycles 1-6 with ctrl_address 0x3FFFE, ctrl_data 0x12345678; req1_ready cycle 7; readback on port 0 returns 0x12345678.
- Both ports request in same cycle after reset -> port 0 granted first (ready cycle 7), port 1 granted cycle 8 (ready cycle 15); repeat tie -> port 1 first.
- Port 0 asserts read and write together -> write performed, req0_rdata unchanged.
- Port 0 drops request at cycle 3 and changes addr -> access finishes at latched addr, ready at cycle 7, ctrl_address constant cycles 1-6.
- rst asserted at cycle 4 of a read -> all outputs to reset values immediately; after release, new read completes in 7 cycles with correct data.
